multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle RV32I core, the successor to the single-cycle controller. A state machine sequences fetch, decode, execute, memory and writeback over several cycles, with a shared datapath and a shared memory port. Memory latency is variable and handshaked through `mem_ready`; a parametrised watchdog converts a stalled access into a sticky bus error. The block sits between the instruction register and the datapath muxes, ALU and register-file enables.

## Interface
Parameters:
- `WAIT_TIMEOUT`, default 16: maximum consecutive wait cycles on a memory access; 0 disables the watchdog.
- `CNT_W`, default 8: watchdog counter width; requires `WAIT_TIMEOUT < 2**CNT_W`.

Ports (all single-clock, synchronous):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7; `funct3` in 3; `funct7b5` in 1: instruction fields, taken from the instruction register.
- `Zero`, `LessThan`, `LessThanUnsigned` in 1 each: ALU compare flags.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `MemWrite` out 1: store.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register load.
- `PCWrite` out 1: PC load.
- `RegWrite` out 1: register-file write.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `immsrc` out 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `ALUControl` out 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- `bus_err` out 1: sticky watchdog error.
- `illegal` out 1: illegal-instruction trap (only with the macro in Configuration).
- `state` out 5: current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP, BUSERR.
- FETCH:
  - Outputs: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10.
  - `IRWrite` and `PCWrite` are asserted only in the cycle `mem_ready`=1; that cycle moves to DECODE.
  - Otherwise the machine holds in FETCH.
- DECODE:
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=01, `immsrc`=B, add (branch target into ALUOut).
  - Dispatch on `op`: 0000011/0100011 → MEMADR; 0110011 → EXR; 0010011 → EXI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode → TRAP.
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add. `immsrc` = S if `op[5]`, else I. Next state: MEMWR if `op[5]`, else MEMRD.
- MEMRD: `mem_req`=1, `AdrSrc`=1; waits for `mem_ready`, then MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEMWR: `mem_req`=1, `AdrSrc`=1, `MemWrite`=1; waits for `mem_ready`, then FETCH.
- EXR: `ALUSrcA`=10, `ALUSrcB`=00 → ALUWB.
  - ALU decode: funct3 000 → add, or sub when `funct7b5`=1.
  - 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (by `funct7b5`), 110 or, 111 and.
- EXI: `ALUSrcA`=10, `ALUSrcB`=01, `immsrc`=I → ALUWB.
  - Same ALU decode as EXR, except funct3=000 is always add.
  - funct3=101 uses `funct7b5` for srai.
- ALUWB: `ResultSrc`=00, `RegWrite`=1 → FETCH.
- BRANCH:
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00.
  - `PCWrite` = cond, where cond by funct3: 000 Zero, 001 !Zero, 100 LessThan, 101 !LessThan, 110 LessThanUnsigned, 111 !LessThanUnsigned.
  - funct3 010/011 → TRAP with `PCWrite`=0. All other funct3 → FETCH.
- JAL:
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `PCWrite`=1.
  - The PC loads the DECODE target held in ALUOut; the ALU computes the link value OldPC+4 → ALUWB.
  - `immsrc`=J. In DECODE the J target is computed when op=JAL: `immsrc`=J for op 1101111.
- JALR: two cycles.
  - Cycle 1: `ALUSrcA`=10, `ALUSrcB`=01, `immsrc`=I, add, latched in ALUOut.
  - Cycle 2: a JAL-style cycle, reached via sub-state flag `jr`. It asserts `PCWrite`, `ResultSrc`=00, `ALUSrcA`=01, `ALUSrcB`=10 → ALUWB.
- LUI: `immsrc`=U, `ALUSrcB`=01, ALU passes the immediate (add, with `ALUSrcA` forced zero, i.e. `ALUSrcA`=11 meaning 0) → ALUWB.
- AUIPC: `ALUSrcA`=01, `ALUSrcB`=01, `immsrc`=U, add → ALUWB.
- Watchdog:
  - `wcnt` clears on every state change and increments each cycle while in FETCH/MEMRD/MEMWR with `mem_ready`=0.
  - When `wcnt`==`WAIT_TIMEOUT`-1 and `mem_ready`=0 → BUSERR.
  - BUSERR: all enables 0, `bus_err`=1, held until reset.
- All unlisted outputs are 0. `ALUControl` defaults to add.

## Timing
- State register, `wcnt` and the JALR flag update on the rising edge of `clk`. Outputs are combinational from state and inputs.
- Reset:
  - Next state is FETCH; `wcnt`=0, `bus_err`=0, `illegal`=0.
  - While `reset`=1, `mem_req`, `MemWrite`, `IRWrite`, `PCWrite` and `RegWrite` are forced 0.
  - Reset mid-access abandons the access.
- Latency at zero wait states: load 5 cycles, store 4, R/I-type 4, branch 3, JAL 4, JALR 5, LUI/AUIPC 4.
- Each cycle with `mem_ready`=0 adds one cycle. `mem_ready` is ignored outside FETCH/MEMRD/MEMWR.
- Simultaneous `mem_ready`=1 and watchdog expiry: ready wins and the access completes.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - TRAP asserts `illegal`=1 with all enables 0, held until reset.
- Macro undefined:
  - TRAP is a single NOP cycle returning to FETCH. The PC was already advanced in FETCH.
  - `illegal` is tied 0.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0) with ready always 1 → states FETCH, DECODE, EXR, ALUWB; `ALUControl`=0000; `RegWrite`=1 in cycle 4 only.
- lw with `mem_ready` low for 3 cycles in MEMRD → 8 cycles total; single `RegWrite` pulse with `ResultSrc`=01.
- bne, with Zero=0 → `PCWrite`=1 in BRANCH; with Zero=1 → `PCWrite`=0; both return to FETCH.
- `WAIT_TIMEOUT`=4 with `mem_ready` stuck 0 in FETCH → BUSERR after 4 cycles, `bus_err`=1; `reset` → FETCH, `bus_err`=0.
- op=0000000 → TRAP: with the macro, `illegal`=1 and stuck; without, FETCH next cycle.
- Assert `reset` in MEMWR → next cycle FETCH, `MemWrite`=0 during reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM with handshaked memory and stall watchdog; define MC_CTRL_ILLEGAL_TRAP_EN for a sticky illegal-instruction trap
module multicycle_controller #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       LessThan,
    input  logic       LessThanUnsigned,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] immsrc,
    output logic [3:0] ALUControl,
    output logic       bus_err,
    output logic       illegal,
    output logic [4:0] state
);
    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP, BUSERR
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

    state_t           cur, nxt;
    logic             jr, jr_nxt, waiting, expired, cond;
    logic [CNT_W-1:0] wcnt;
    logic [3:0]       alu_dec;

    assign state   = cur;
    assign bus_err = cur == BUSERR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = cur == TRAP;
`else
    assign illegal = 1'b0;
`endif
    assign waiting = (cur == FETCH || cur == MEMRD || cur == MEMWR) && !mem_ready;
    assign expired = WAIT_TIMEOUT != 0 && waiting && wcnt == LAST;
    assign cond    = (funct3[2] ? (funct3[1] ? LessThanUnsigned : LessThan) : Zero) ^ funct3[0];

    // funct3 to ALU operation; sub exists only for R-type, sra for both shift forms
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (cur == EXR && funct7b5) ? 4'b0001 : 4'b0000;
            3'b001:  alu_dec = 4'b0111;
            3'b010:  alu_dec = 4'b0101;
            3'b011:  alu_dec = 4'b0110;
            3'b100:  alu_dec = 4'b0100;
            3'b101:  alu_dec = funct7b5 ? 4'b1001 : 4'b1000;
            3'b110:  alu_dec = 4'b0011;
            default: alu_dec = 4'b0010;
        endcase
    end

    // next state and datapath controls; reset masks every enable so an access is dropped
    always_comb begin
        nxt        = cur;
        jr_nxt     = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        immsrc     = 3'b000;
        ALUControl = 4'b0000;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nxt       = mem_ready ? DECODE : expired ? BUSERR : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immsrc  = op == 7'b1101111 ? 3'b011 : 3'b010;
                case (op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXR;
                    7'b0010011:             nxt = EXI;
                    7'b1100011:             nxt = BRANCH;
                    7'b1101111:             nxt = JAL;
                    7'b1100111:             nxt = JALR;
                    7'b0110111:             nxt = LUI;
                    7'b0010111:             nxt = AUIPC;
                    default:                nxt = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immsrc  = {2'b00, op[5]};
                nxt     = op[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                nxt     = mem_ready ? MEMWB : expired ? BUSERR : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                nxt       = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                nxt      = mem_ready ? FETCH : expired ? BUSERR : MEMWR;
            end
            EXR, EXI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = {1'b0, cur == EXI};
                ALUControl = alu_dec;
                nxt        = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 4'b0001;
                PCWrite    = cond && funct3[2:1] != 2'b01;
                nxt        = funct3[2:1] == 2'b01 ? TRAP : FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                immsrc  = 3'b011;
                PCWrite = 1'b1;
                nxt     = ALUWB;
            end
            JALR: begin
                ALUSrcA = jr ? 2'b01 : 2'b10;
                ALUSrcB = jr ? 2'b10 : 2'b01;
                PCWrite = jr;
                jr_nxt  = !jr;
                nxt     = jr ? ALUWB : JALR;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                immsrc  = 3'b100;
                nxt     = ALUWB;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immsrc  = 3'b100;
                nxt     = ALUWB;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            TRAP:    nxt = TRAP;
`else
            TRAP:    nxt = FETCH;
`endif
            default: nxt = BUSERR;
        endcase
        if (reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // state, JALR second-cycle flag and watchdog; wcnt restarts whenever the state moves
    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= FETCH;
            jr   <= 1'b0;
            wcnt <= '0;
        end else begin
            cur  <= nxt;
            jr   <= jr_nxt;
            wcnt <= nxt != cur ? '0 : waiting ? wcnt + 1'b1 : wcnt;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream checked against a per-instruction cycle-sequence model
module tb_multicycle_controller;
    localparam int WT = 4;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
    localparam int S_EXR = 6, S_EXI = 7, S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10, S_JALR = 11;
    localparam int S_LUI = 12, S_AUIPC = 13, S_TRAP = 14, S_BUSERR = 15;
    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_JALR = 6;
    localparam int C_LUI = 7, C_AUIPC = 8, C_ILL = 9;
    localparam int M_NORM = 0, M_STUCK = 1, M_ABORT = 2;

    logic clk = 1'b0;
    logic reset, funct7b5, Zero, LessThan, LessThanUnsigned, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, bus_err, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] immsrc;
    logic [3:0] ALUControl;
    logic [4:0] state;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_TIMEOUT(WT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LessThan(LessThan), .LessThanUnsigned(LessThanUnsigned),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .immsrc(immsrc), .ALUControl(ALUControl),
        .bus_err(bus_err), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic       rst, rdy;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, ltu;
        logic [4:0] st;
        logic       mreq, mw, adr, irw, pcw, rw;
        logic [1:0] a, b, res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       berr, ill;
    } rec_t;

    rec_t q[$];
    rec_t c, want;
    logic chk = 1'b0;
    int checks = 0, errors = 0;
    int tr_st[$], tr_pc[$], tr_rw[$], tr_alu[$], tr_be[$], tr_ill[$], tr_mw[$];
    logic [6:0] i_op;
    logic [2:0] i_f3;
    logic i_f7, i_z, i_lt, i_ltu;
    logic [6:0] opc [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    int alu_tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("state", state, want.st);
            check("mem_req", mem_req, want.mreq);
            check("MemWrite", MemWrite, want.mw);
            check("AdrSrc", AdrSrc, want.adr);
            check("IRWrite", IRWrite, want.irw);
            check("PCWrite", PCWrite, want.pcw);
            check("RegWrite", RegWrite, want.rw);
            check("ALUSrcA", ALUSrcA, want.a);
            check("ALUSrcB", ALUSrcB, want.b);
            check("ResultSrc", ResultSrc, want.res);
            check("immsrc", immsrc, want.imm);
            check("ALUControl", ALUControl, want.alu);
            if (!want.rst) begin
                check("bus_err", bus_err, want.berr);
                check("illegal", illegal, want.ill);
            end
            tr_st.push_back(int'(state));
            tr_pc.push_back(int'(PCWrite));
            tr_rw.push_back(int'(RegWrite));
            tr_alu.push_back(int'(ALUControl));
            tr_be.push_back(int'(bus_err));
            tr_ill.push_back(int'(illegal));
            tr_mw.push_back(int'(MemWrite));
        end
    end

    task automatic tr_clear();
        tr_st.delete(); tr_pc.delete(); tr_rw.delete(); tr_alu.delete();
        tr_be.delete(); tr_ill.delete(); tr_mw.delete();
    endtask

    task automatic set_i(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        i_op = o; i_f3 = f3; i_f7 = f7; i_z = z; i_lt = 1'b0; i_ltu = 1'b0;
    endtask

    task automatic cyc(input int st);
        c = '0;
        c.st = st[4:0];
        c.op = i_op; c.f3 = i_f3; c.f7 = i_f7; c.z = i_z; c.lt = i_lt; c.ltu = i_ltu;
        c.rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic mem_fields(input int st, input bit active);
        c.mreq = active;
        c.adr = st != S_FETCH;
        c.mw = active && st == S_MEMWR;
        if (st == S_FETCH) begin
            c.b = 2'd2;
            c.res = 2'd2;
        end
    endtask

    task automatic halt(input int st);
        for (int k = 0; k < 3; k++) begin
            cyc(st);
            c.berr = st == S_BUSERR;
            c.ill = st == S_TRAP;
            c.rst = k == 2;
            q.push_back(c);
        end
    endtask

    task automatic mem_phase(input int st, input int waits, input int mode);
        int n;
        n = mode == M_NORM ? waits + 1 : mode == M_STUCK ? WT : 1;
        for (int w = 0; w < n; w++) begin
            cyc(st);
            mem_fields(st, 1'b1);
            c.rdy = mode == M_NORM && w == n - 1;
            if (st == S_FETCH && c.rdy) begin
                c.irw = 1'b1;
                c.pcw = 1'b1;
            end
            q.push_back(c);
        end
        if (mode == M_STUCK) halt(S_BUSERR);
        if (mode == M_ABORT) begin
            cyc(st);
            mem_fields(st, 1'b0);
            c.rst = 1'b1;
            c.rdy = 1'b1;
            q.push_back(c);
        end
    endtask

    task automatic trap();
        cyc(S_TRAP);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        c.ill = 1'b1;
        q.push_back(c);
        halt(S_TRAP);
`else
        q.push_back(c);
`endif
    endtask

    task automatic wb();
        cyc(S_ALUWB);
        c.rw = 1'b1;
        q.push_back(c);
    endtask

    function automatic logic [3:0] alu_exp(input bit r);
        bit alt;
        alt = i_f3 == 3'd5 ? i_f7 : (i_f3 == 3'd0 && r && i_f7);
        return 4'(alu_tab[i_f3] + int'(alt));
    endfunction

    function automatic logic taken();
        case (i_f3)
            3'd0:    return i_z;
            3'd1:    return !i_z;
            3'd4:    return i_lt;
            3'd5:    return !i_lt;
            3'd6:    return i_ltu;
            3'd7:    return !i_ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic build(input int cls, input int wf, input int wm, input int mode);
        mem_phase(S_FETCH, wf, M_NORM);
        cyc(S_DECODE);
        c.a = 2'd1; c.b = 2'd1;
        c.imm = cls == C_JAL ? 3'd3 : 3'd2;
        q.push_back(c);
        case (cls)
            C_LOAD, C_STORE: begin
                cyc(S_MEMADR);
                c.a = 2'd2; c.b = 2'd1;
                c.imm = cls == C_STORE ? 3'd1 : 3'd0;
                q.push_back(c);
                mem_phase(cls == C_STORE ? S_MEMWR : S_MEMRD, wm, mode);
                if (cls == C_LOAD && mode == M_NORM) begin
                    cyc(S_MEMWB);
                    c.res = 2'd1; c.rw = 1'b1;
                    q.push_back(c);
                end
            end
            C_R, C_I: begin
                cyc(cls == C_R ? S_EXR : S_EXI);
                c.a = 2'd2;
                c.b = cls == C_I ? 2'd1 : 2'd0;
                c.alu = alu_exp(cls == C_R);
                q.push_back(c);
                wb();
            end
            C_BR: begin
                cyc(S_BRANCH);
                c.a = 2'd2; c.alu = 4'd1; c.pcw = taken();
                q.push_back(c);
                if (i_f3 == 3'd2 || i_f3 == 3'd3) trap();
            end
            C_JAL: begin
                cyc(S_JAL);
                c.a = 2'd1; c.b = 2'd2; c.imm = 3'd3; c.pcw = 1'b1;
                q.push_back(c);
                wb();
            end
            C_JALR: begin
                cyc(S_JALR);
                c.a = 2'd2; c.b = 2'd1;
                q.push_back(c);
                cyc(S_JALR);
                c.a = 2'd1; c.b = 2'd2; c.pcw = 1'b1;
                q.push_back(c);
                wb();
            end
            C_LUI: begin
                cyc(S_LUI);
                c.a = 2'd3; c.b = 2'd1; c.imm = 3'd4;
                q.push_back(c);
                wb();
            end
            C_AUIPC: begin
                cyc(S_AUIPC);
                c.a = 2'd1; c.b = 2'd1; c.imm = 3'd4;
                q.push_back(c);
                wb();
            end
            default: trap();
        endcase
    endtask

    task automatic play();
        rec_t r;
        while (q.size() != 0) begin
            r = q.pop_front();
            reset = r.rst; mem_ready = r.rdy; op = r.op; funct3 = r.f3; funct7b5 = r.f7;
            Zero = r.z; LessThan = r.lt; LessThanUnsigned = r.ltu;
            want = r;
            chk = 1'b1;
            @(posedge clk);
            #1;
        end
        chk = 1'b0;
    endtask

    function automatic bit legal(input logic [6:0] o);
        foreach (opc[k]) if (opc[k] == o) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int cls, md, s;
        reset = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
        Zero = 1'b0; LessThan = 1'b0; LessThanUnsigned = 1'b0;
        @(posedge clk);
        #1;
        set_i(7'b0110011, 3'd0, 1'b0, 1'b0);
        tr_clear();
        cyc(S_FETCH);
        mem_fields(S_FETCH, 1'b0);
        c.rst = 1'b1; c.rdy = 1'b1;
        q.push_back(c);
        play();
        check("lit_reset_state", tr_st[0], 0);

        tr_clear();
        build(C_R, 0, 0, M_NORM);
        play();
        check("lit_add_s1", tr_st[1], 1);
        check("lit_add_s2", tr_st[2], 6);
        check("lit_add_s3", tr_st[3], 8);
        check("lit_add_alu", tr_alu[2], 0);
        check("lit_add_rw", {tr_rw[0][0], tr_rw[1][0], tr_rw[2][0], tr_rw[3][0]}, 4'b0001);

        set_i(7'b0000011, 3'd2, 1'b0, 1'b0);
        tr_clear();
        build(C_LOAD, 0, 3, M_NORM);
        play();
        s = 0;
        foreach (tr_rw[k]) s += tr_rw[k];
        check("lit_lw_len", tr_st.size(), 8);
        check("lit_lw_s6", tr_st[6], 3);
        check("lit_lw_s7", tr_st[7], 4);
        check("lit_lw_rwcount", s, 1);

        set_i(7'b1100011, 3'd1, 1'b0, 1'b0);
        tr_clear();
        build(C_BR, 0, 0, M_NORM);
        play();
        check("lit_bne_taken", tr_pc[2], 1);
        set_i(7'b1100011, 3'd1, 1'b0, 1'b1);
        tr_clear();
        build(C_BR, 0, 0, M_NORM);
        set_i(7'b0110011, 3'd0, 1'b1, 1'b0);
        build(C_R, 3, 0, M_NORM);
        play();
        check("lit_bne_nottaken", tr_pc[2], 0);
        check("lit_bne_ret", tr_st[3], 0);
        check("lit_ready_wins", tr_st[7], 1);

        tr_clear();
        mem_phase(S_FETCH, 0, M_STUCK);
        build(C_R, 0, 0, M_NORM);
        play();
        check("lit_wd_s3", tr_st[3], 0);
        check("lit_wd_s4", tr_st[4], 15);
        check("lit_wd_err", tr_be[4], 1);
        check("lit_wd_rst_s", tr_st[7], 0);
        check("lit_wd_rst_err", tr_be[7], 0);

        set_i(7'b0000000, 3'd0, 1'b0, 1'b0);
        tr_clear();
        build(C_ILL, 0, 0, M_NORM);
        set_i(7'b0110011, 3'd0, 1'b0, 1'b0);
        build(C_R, 0, 0, M_NORM);
        play();
        check("lit_trap_s", tr_st[2], 14);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        check("lit_trap_ill", tr_ill[2], 1);
        check("lit_trap_stuck", tr_st[4], 14);
        check("lit_trap_rst", tr_st[6], 0);
`else
        check("lit_trap_ill", tr_ill[2], 0);
        check("lit_trap_next", tr_st[3], 0);
`endif

        set_i(7'b0100011, 3'd2, 1'b0, 1'b0);
        tr_clear();
        build(C_STORE, 0, 0, M_ABORT);
        set_i(7'b0110011, 3'd0, 1'b0, 1'b0);
        build(C_R, 0, 0, M_NORM);
        play();
        check("lit_abort_mw_before", tr_mw[3], 1);
        check("lit_abort_mw_rst", tr_mw[4], 0);
        check("lit_abort_s", tr_st[4], 5);
        check("lit_abort_next", tr_st[5], 0);

        for (int n = 0; n < 400; n++) begin
            cls = $urandom_range(0, 9);
            i_f3 = 3'($urandom); i_f7 = 1'($urandom);
            i_z = 1'($urandom); i_lt = 1'($urandom); i_ltu = 1'($urandom);
            if (cls == C_ILL) begin
                i_op = 7'($urandom);
                while (legal(i_op)) i_op = 7'($urandom);
            end else begin
                i_op = opc[cls];
            end
            md = $urandom_range(0, 19);
            md = md == 0 ? M_STUCK : md == 1 ? M_ABORT : M_NORM;
            build(cls, $urandom_range(0, WT - 1), $urandom_range(0, WT - 1), md);
            play();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
